qubit_coord_decoder: RTL and testbench
======================================

Name: qubit_coord_decoder

Overview:
- Reverse of the grid coordinate lookup: takes a detected spot coordinate (x, y) and returns the 10x10 qubit index it lands on.
- Returns a hit flag when the spot is within tolerance of a lattice site, plus the row and column.
- Sits between the camera spot-centroid stage and the per-qubit occupancy/readout logic.
- Uses a fixed-latency sequential subtract-divide, so no divider is inferred.

Parameters:
- COORD_WIDTH, 10, width of the x/y coordinates.
- GRID_COLS, 10, lattice columns.
- GRID_ROWS, 10, lattice rows.
- QUBIT_START_X, 100, x of qubit 0.
- QUBIT_START_Y, 100, y of qubit 0.
- QUBIT_SPACING, 20, pitch in pixels on both axes. Must be even.
- TOLERANCE, 4, maximum |offset| from a site centre for a hit. Must be < QUBIT_SPACING/2.
- IDX_W, $clog2(GRID_COLS*GRID_ROWS), index width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_coord_valid  in  1  input coordinate valid
- o_coord_ready  out  1  decoder can accept a coordinate
- i_x  in  COORD_WIDTH  spot x
- i_y  in  COORD_WIDTH  spot y
- o_result_valid  out  1  result valid
- i_result_ready  in  1  downstream accepts result
- o_hit  out  1  coordinate maps to a qubit within tolerance
- o_index  out  IDX_W  row*GRID_COLS+col; 0 on miss
- o_row  out  $clog2(GRID_ROWS)  row; 0 on miss
- o_col  out  $clog2(GRID_COLS)  column; 0 on miss

Behaviour:
- Reset: clock and reset are i_clk and i_rst_n. Reset is asynchronous, active-low, and forces state IDLE. All result registers clear to 0: o_result_valid, o_hit, o_index, o_row, o_col. o_coord_ready reads 1 in IDLE.
- Constants: HALF = QUBIT_SPACING/2; N = max(GRID_COLS, GRID_ROWS).
- FSM states: IDLE, DIV, CHECK, OUT.
- IDLE:
  - o_coord_ready = 1.
  - On i_coord_valid, capture bx = i_x + HALF - QUBIT_START_X and by = i_y + HALF - QUBIT_START_Y. Both are signed, COORD_WIDTH+2 bits.
  - Clear quotients qx and qy and the cycle counter, then go to DIV.
- DIV: runs exactly N cycles. Each cycle, independently per axis: if remainder >= QUBIT_SPACING, subtract QUBIT_SPACING and increment the quotient; otherwise hold. A negative remainder is held unchanged. Go to CHECK after N cycles.
- CHECK (1 cycle):
  - Offsets: offx = rx - HALF, offy = ry - HALF.
  - Hit requires all of: bx >= 0, by >= 0, rx < QUBIT_SPACING, ry < QUBIT_SPACING, qx < GRID_COLS, qy < GRID_ROWS, |offx| <= TOLERANCE, |offy| <= TOLERANCE.
  - On hit: register o_row = qy, o_col = qx, o_index = qy*GRID_COLS + qx.
  - On miss: o_row, o_col and o_index are all 0.
  - Set o_result_valid = 1 and go to OUT.
- OUT:
  - Outputs are held stable while i_result_ready = 0.
  - When o_result_valid && i_result_ready: clear o_result_valid and return to IDLE.
  - o_coord_ready = 0 in OUT, so there is no same-cycle accept.
- Latency: an accept at cycle 0 gives o_result_valid high at cycle N+2 (12 with defaults). Throughput is one coordinate per N+3 cycles when the result is taken immediately.
- o_coord_ready = 0 in DIV, CHECK and OUT. i_coord_valid is ignored there and its data is not sampled.
- Reset asserted mid-DIV or in OUT aborts immediately: the in-flight result is discarded and o_result_valid = 0.
- Exactly-on-boundary offsets (|off| == TOLERANCE) are hits.

Test Plan:
- Reset, then (100,100) -> o_coord_ready drops for N+2 cycles. Result: o_result_valid at cycle 12, hit=1, index=0, row=0, col=0.
- (283,163) -> bx=193, qx=9, offx=3; by=73, qy=3, offy=3. Result: hit=1, row=3, col=9, index=39.
- Tolerance edges:
  - (96,104) -> offx=-4, offy=4, hit=1, index=0.
  - (125,100) -> offx=5, miss: hit=0, index=0.
- Out of grid:
  - (85,100) -> bx=-5, miss.
  - (300,100) -> qx=10, miss.
  - (100,291) -> by=201, qy=10, miss.
- Backpressure: i_result_ready low for 5 cycles after valid -> o_hit, o_index, o_row, o_col stable. o_coord_ready stays 0; a new i_coord_valid is ignored until the handshake completes.
- Reset pulse in DIV cycle 4 -> o_result_valid=0 and o_coord_ready=1. A subsequent (120,120) completes normally: row=1, col=1, index=11.

Source files
------------

// File: rtl/qubit_coord_decoder.sv
// qubit_coord_decoder: maps a camera spot centroid (x, y) back onto the
// GRID_ROWS x GRID_COLS qubit lattice. A fixed N-cycle repeated-subtract
// divide finds the lattice cell on each axis, then the remainder is
// checked against TOLERANCE around the site centre to decide hit/miss.
module qubit_coord_decoder #(
  parameter int COORD_WIDTH   = 10,
  parameter int GRID_COLS     = 10,
  parameter int GRID_ROWS     = 10,
  parameter int QUBIT_START_X = 100,
  parameter int QUBIT_START_Y = 100,
  parameter int QUBIT_SPACING = 20,
  parameter int TOLERANCE     = 4,
  parameter int IDX_W         = $clog2(GRID_COLS*GRID_ROWS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_coord_valid,
  output logic                          o_coord_ready,
  input  logic [COORD_WIDTH-1:0]        i_x,
  input  logic [COORD_WIDTH-1:0]        i_y,
  output logic                          o_result_valid,
  input  logic                          i_result_ready,
  output logic                          o_hit,
  output logic [IDX_W-1:0]              o_index,
  output logic [$clog2(GRID_ROWS)-1:0]  o_row,
  output logic [$clog2(GRID_COLS)-1:0]  o_col
);

  localparam int HALF  = QUBIT_SPACING / 2;
  localparam int N     = (GRID_COLS > GRID_ROWS) ? GRID_COLS : GRID_ROWS;
  localparam int SW    = COORD_WIDTH + 2;
  localparam int QW    = $clog2(N + 1);
  localparam int CNTW  = $clog2(N + 1);
  localparam int ROW_W = $clog2(GRID_ROWS);
  localparam int COL_W = $clog2(GRID_COLS);

  localparam logic signed [SW-1:0] SPACING_S = SW'(QUBIT_SPACING);
  localparam logic signed [SW-1:0] HALF_S    = SW'(HALF);
  localparam logic signed [SW-1:0] TOL_S     = SW'(TOLERANCE);
  localparam logic signed [SW-1:0] START_X_S = SW'(QUBIT_START_X);
  localparam logic signed [SW-1:0] START_Y_S = SW'(QUBIT_START_Y);

  typedef enum logic [1:0] {IDLE, DIV, CHECK, OUT} state_t;

  state_t state, next_state;

  logic                 bx_neg, by_neg;
  logic signed [SW-1:0] rx, ry;
  logic [QW-1:0]        qx, qy;
  logic [CNTW-1:0]      cnt;

  logic signed [SW-1:0] cap_x, cap_y;
  logic signed [SW-1:0] offx, offy;
  logic                 hit_c;

  // Base offsets: shifting by HALF puts each site centre in the middle of a cell
  always_comb begin
    cap_x = $signed({2'b00, i_x}) + HALF_S - START_X_S;
    cap_y = $signed({2'b00, i_y}) + HALF_S - START_Y_S;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_coord_valid)       next_state = DIV;
      DIV:     if (cnt == CNTW'(N - 1)) next_state = CHECK;
      CHECK:                            next_state = OUT;
      OUT:     if (i_result_ready)      next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    o_coord_ready  = (state == IDLE);
    o_result_valid = (state == OUT);
  end

  // Hit test on the final remainders and quotients
  always_comb begin
    offx  = rx - HALF_S;
    offy  = ry - HALF_S;
    hit_c = !bx_neg && !by_neg &&
            (rx < SPACING_S) && (ry < SPACING_S) &&
            (qx < QW'(GRID_COLS)) && (qy < QW'(GRID_ROWS)) &&
            (offx >= -TOL_S) && (offx <= TOL_S) &&
            (offy >= -TOL_S) && (offy <= TOL_S);
  end

  // Capture, iterative divide and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bx_neg  <= 1'b0;
      by_neg  <= 1'b0;
      rx      <= '0;
      ry      <= '0;
      qx      <= '0;
      qy      <= '0;
      cnt     <= '0;
      o_hit   <= 1'b0;
      o_index <= '0;
      o_row   <= '0;
      o_col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_coord_valid) begin
            bx_neg <= cap_x[SW-1];
            by_neg <= cap_y[SW-1];
            rx     <= cap_x;
            ry     <= cap_y;
            qx     <= '0;
            qy     <= '0;
            cnt    <= '0;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          // Negative remainders fail the signed compare and are left untouched
          if (rx >= SPACING_S) begin
            rx <= rx - SPACING_S;
            qx <= qx + 1'b1;
          end
          if (ry >= SPACING_S) begin
            ry <= ry - SPACING_S;
            qy <= qy + 1'b1;
          end
        end
        CHECK: begin
          o_hit <= hit_c;
          if (hit_c) begin
            o_row   <= ROW_W'(qy);
            o_col   <= COL_W'(qx);
            o_index <= IDX_W'(qy) * IDX_W'(GRID_COLS) + IDX_W'(qx);
          end else begin
            o_row   <= '0;
            o_col   <= '0;
            o_index <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qubit_coord_decoder.sv
// Directed bench for qubit_coord_decoder with hand-computed expectations.
module tb_qubit_coord_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coord_valid = 1'b0;
  logic       coord_ready;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       result_valid;
  logic       result_ready = 1'b1;
  logic       hit;
  logic [6:0] index;
  logic [3:0] row;
  logic [3:0] col;

  int checks = 0;
  int errors = 0;

  qubit_coord_decoder #(
    .COORD_WIDTH(10), .GRID_COLS(10), .GRID_ROWS(10),
    .QUBIT_START_X(100), .QUBIT_START_Y(100),
    .QUBIT_SPACING(20), .TOLERANCE(4)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_coord_valid(coord_valid),
    .o_coord_ready(coord_ready),
    .i_x(x),
    .i_y(y),
    .o_result_valid(result_valid),
    .i_result_ready(result_ready),
    .o_hit(hit),
    .o_index(index),
    .o_row(row),
    .o_col(col)
  );

  always #5 clk = ~clk;

  // Present one coordinate for one clock; the decoder must be ready
  task automatic accept(input logic [9:0] ax, input logic [9:0] ay);
    coord_valid = 1'b1;
    x = ax;
    y = ay;
    checks++;
    if (coord_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready (%0d,%0d): got %b want 1", ax, ay, coord_ready);
    end
    @(posedge clk); #1;
    coord_valid = 1'b0;
  endtask

  // Edges after the accepting edge until result valid; -1 on timeout
  task automatic wait_valid(output int lat);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (result_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (result_valid !== 1'b0 || hit !== 1'b0 || index !== 7'd0 ||
        row !== 4'd0 || col !== 4'd0 || coord_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b hit=%b idx=%0d row=%0d col=%0d ready=%b want 0 0 0 0 0 1",
               result_valid, hit, index, row, col, coord_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // (100,100): site 0 dead centre; checks latency and ready-low window
  task automatic test_first();
    int lat;
    int low;
    accept(10'd100, 10'd100);
    lat = 0;
    low = 0;
    while (lat < 40) begin
      if (coord_ready === 1'b0) low++;
      if (result_valid === 1'b1) break;
      @(posedge clk); #1;
      lat++;
    end
    // valid in cycle N+2 means N+1 edges after the accepting edge
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL first_latency: got %0d want 11", lat);
    end
    checks++;
    if (low !== 12) begin
      errors++;
      $display("FAIL first_ready_low: got %0d cycles want 12", low);
    end
    checks++;
    if (hit !== 1'b1 || index !== 7'd0 || row !== 4'd0 || col !== 4'd0) begin
      errors++;
      $display("FAIL first_result: hit=%b idx=%0d row=%0d col=%0d want 1 0 0 0", hit, index, row, col);
    end
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || coord_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_handshake: valid=%b ready=%b want 0 1", result_valid, coord_ready);
    end
  endtask

  task automatic test_decode();
    int lat;
    accept(10'd283, 10'd163);
    wait_valid(lat);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL decode_latency: got %0d want 11", lat);
    end
    checks++;
    if (hit !== 1'b1 || index !== 7'd39 || row !== 4'd3 || col !== 4'd9) begin
      errors++;
      $display("FAIL decode_283_163: hit=%b idx=%0d row=%0d col=%0d want 1 39 3 9", hit, index, row, col);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tolerance();
    logic [9:0] vx [4] = '{10'd96, 10'd125, 10'd104, 10'd100};
    logic [9:0] vy [4] = '{10'd104, 10'd100, 10'd96, 10'd115};
    logic       eh [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept(vx[i], vy[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 11) begin
        errors++;
        $display("FAIL tol_latency[%0d]: got %0d want 11", i, lat);
      end
      checks++;
      if (hit !== eh[i] || index !== 7'd0 || row !== 4'd0 || col !== 4'd0) begin
        errors++;
        $display("FAIL tol[%0d] (%0d,%0d): hit=%b idx=%0d row=%0d col=%0d want %b 0 0 0",
                 i, vx[i], vy[i], hit, index, row, col, eh[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_out_of_grid();
    logic [9:0] vx [4] = '{10'd85, 10'd300, 10'd100, 10'd1000};
    logic [9:0] vy [4] = '{10'd100, 10'd100, 10'd291, 10'd100};
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept(vx[i], vy[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 11) begin
        errors++;
        $display("FAIL oog_latency[%0d]: got %0d want 11", i, lat);
      end
      checks++;
      if (hit !== 1'b0 || index !== 7'd0 || row !== 4'd0 || col !== 4'd0) begin
        errors++;
        $display("FAIL oog[%0d] (%0d,%0d): hit=%b idx=%0d row=%0d col=%0d want 0 0 0 0",
                 i, vx[i], vy[i], hit, index, row, col);
      end
      @(posedge clk); #1;
    end
  endtask

  // Last lattice site (row 9, col 9): index 99
  task automatic test_corner();
    int lat;
    accept(10'd280, 10'd280);
    wait_valid(lat);
    checks++;
    if (lat !== 11 || hit !== 1'b1 || index !== 7'd99 || row !== 4'd9 || col !== 4'd9) begin
      errors++;
      $display("FAIL corner_280_280: lat=%0d hit=%b idx=%0d row=%0d col=%0d want 11 1 99 9 9",
               lat, hit, index, row, col);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    result_ready = 1'b0;
    accept(10'd283, 10'd163);
    wait_valid(lat);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 11", lat);
    end
    // A competing request during the stall must be ignored
    coord_valid = 1'b1;
    x = 10'd120;
    y = 10'd120;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (result_valid !== 1'b1 || coord_ready !== 1'b0 || hit !== 1'b1 ||
          index !== 7'd39 || row !== 4'd3 || col !== 4'd9) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b hit=%b idx=%0d row=%0d col=%0d want 1 0 1 39 3 9",
                 c, result_valid, coord_ready, hit, index, row, col);
      end
    end
    coord_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || coord_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 1", result_valid, coord_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (coord_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_stale_accept: ready=%b want 1", coord_ready);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    accept(10'd283, 10'd163);
    // accepting edge starts DIV cycle 1; three more edges reach DIV cycle 4
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || coord_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_div: valid=%b ready=%b want 0 1", result_valid, coord_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept(10'd120, 10'd120);
    wait_valid(lat);
    checks++;
    if (lat !== 11 || hit !== 1'b1 || index !== 7'd11 || row !== 4'd1 || col !== 4'd1) begin
      errors++;
      $display("FAIL after_reset_120_120: lat=%0d hit=%b idx=%0d row=%0d col=%0d want 11 1 11 1 1",
               lat, hit, index, row, col);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_out();
    int lat;
    result_ready = 1'b0;
    accept(10'd120, 10'd120);
    wait_valid(lat);
    rst_n = 1'b0;
    #1;
    checks++;
    if (lat !== 11 || result_valid !== 1'b0 || hit !== 1'b0 || index !== 7'd0 || coord_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_out: lat=%0d valid=%b hit=%b idx=%0d ready=%b want 11 0 0 0 1",
               lat, result_valid, hit, index, coord_ready);
    end
    result_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_first();
    test_decode();
    test_tolerance();
    test_out_of_grid();
    test_corner();
    test_backpressure();
    test_reset_mid_div();
    test_reset_in_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
